// File: rtl/addsub_result_if.sv
// Handshake bundle between the add/sub result FIFO and its producer/consumer.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface addsub_result_if;
   logic [3:0] sum_in;
   logic       carry_in;
   logic       control_in;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] sum_out;
   logic       carry_out;
   logic       op_out;
   logic [2:0] flags_out;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count_out;
   logic       drop_out;
   logic       clr_in;

   modport slave (
      input  sum_in, carry_in, control_in, in_valid, out_ready, clr_in,
      output in_ready, sum_out, carry_out, op_out, flags_out, out_valid,
      count_out, drop_out
   );

   modport master (
      output sum_in, carry_in, control_in, in_valid, out_ready, clr_in,
      input  in_ready, sum_out, carry_out, op_out, flags_out, out_valid,
      count_out, drop_out
   );
endinterface

// File: rtl/addsub_result_fifo.sv
// 4-entry result FIFO for a 4-bit adder/subtractor, with sticky overflow-drop flag.
// Define ADDSUB_RESULT_FLAGS_EN to store {zero, negative, borrow} flags per entry.
module addsub_result_fifo (
   input logic            clk,
   input logic            rst_n,
   addsub_result_if.slave bus
);
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0] sum;
      logic       carry;
      logic       op;
   } entry_t;

   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       drop_q, drop_d;
   entry_t     head_q, head_d;
   entry_t     mem_q [DEPTH];
   entry_t     mem_d [DEPTH];
   entry_t     new_entry;
   logic       push, pop;

`ifdef ADDSUB_RESULT_FLAGS_EN
   logic [2:0] fmem_q [DEPTH];
   logic [2:0] fmem_d [DEPTH];
   logic [2:0] flags_q, flags_d;

   function automatic logic [2:0] calc_flags(input logic [3:0] s, input logic c, input logic op);
      return {(s == 4'd0), s[3], op & ~c};
   endfunction
`endif

   always_comb begin
      push      = bus.in_valid && (count_q != 3'd4);
      pop       = (count_q != 3'd0) && bus.out_ready;
      new_entry = '{sum: bus.sum_in, carry: bus.carry_in, op: bus.control_in};

      wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + 3'd1;
      else if (!push && pop) count_d = count_q - 3'd1;

      // A drop in the same cycle as clr_in must still leave the flag set.
      drop_d = drop_q;
      if (bus.in_valid && (count_q == 3'd4)) drop_d = 1'b1;
      else if (bus.clr_in)                    drop_d = 1'b0;

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = new_entry;

      // Head register tracks the entry that will sit at the read pointer; reading
      // mem_d covers the case where that entry is being written this very cycle.
      head_d = head_q;
      if (count_d != 3'd0) head_d = mem_d[rd_ptr_d];
   end

`ifdef ADDSUB_RESULT_FLAGS_EN
   always_comb begin
      fmem_d = fmem_q;
      if (push) fmem_d[wr_ptr_q] = calc_flags(bus.sum_in, bus.carry_in, bus.control_in);
      flags_d = flags_q;
      if (count_d != 3'd0) flags_d = fmem_d[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      fmem_q <= fmem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= 3'b000;
      else        flags_q <= flags_d;
   end

   assign bus.flags_out = flags_q;
`else
   assign bus.flags_out = 3'b000;
`endif

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         drop_q   <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         head_q   <= head_d;
      end
   end

   assign bus.in_ready  = (count_q != 3'd4);
   assign bus.out_valid = (count_q != 3'd0);
   assign bus.count_out = count_q;
   assign bus.drop_out  = drop_q;
   assign bus.sum_out   = head_q.sum;
   assign bus.carry_out = head_q.carry;
   assign bus.op_out    = head_q.op;
endmodule

// File: doc/addsub_result_fifo.md
ADDSUB_RESULT_FIFO -- requirements
Module: addsub_result_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-002 sum_in input 4 SHALL carry the 4-bit add/sub result from the upstream 4-bit adder/subtractor.
REQ-003 carry_in input 1 SHALL carry the upstream carry_out.
REQ-004 control_in input 1 SHALL carry the operation that produced the result: 0 = add, 1 = subtract.
REQ-005 in_valid input 1 SHALL mark sum_in/carry_in/control_in as valid this cycle.
REQ-006 in_ready output 1 SHALL indicate the FIFO can accept an entry this cycle.
REQ-007 sum_out output 4, carry_out output 1 and op_out output 1 SHALL present the head entry.
REQ-008 flags_out output 3 SHALL present the head entry's flags {zero, negative, borrow}.
REQ-009 out_valid output 1 SHALL mark the head entry valid; out_ready input 1 SHALL mark the consumer accepting it.
REQ-010 count_out output 3 SHALL give the current occupancy, 0..4.
REQ-011 drop_out output 1 SHALL be a sticky flag set when a valid input arrives while the FIFO is full; clr_in input 1 SHALL clear it synchronously.

Function
REQ-012 Storage SHALL be 4 entries of {sum[3:0], carry, op, flags[2:0]}, organised as a circular buffer with 2-bit read and write pointers that wrap 3->0.
REQ-013 Push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (count_out != 4), as a combinational decode of registered state with no path from in_valid or out_ready.
REQ-015 out_valid SHALL equal (count_out != 0); head outputs SHALL be driven from the entry at the read pointer.
REQ-016 Latency: an entry pushed into an empty FIFO SHALL appear on out_valid/sum_out in the cycle after the push edge; there is no same-cycle bypass.
REQ-017 Simultaneous push and pop with 0<count<4 SHALL leave count unchanged and advance both pointers.
REQ-018 When full, in_ready=0, so no push SHALL occur even if a pop happens in the same cycle.
REQ-019 in_valid=1 while full SHALL set drop_out on that edge and the input SHALL be discarded.
REQ-020 If clr_in and a drop event coincide, set SHALL win and drop_out SHALL read 1.
REQ-021 When out_valid=0, head outputs SHALL hold their last value and carry no meaning.
REQ-022 Flag definitions, computed at push time: zero = (sum_in==0); negative = sum_in[3]; borrow = control_in & ~carry_in.
REQ-023 An out_ready pulse while empty, or an in_valid=0 cycle, SHALL not change state.

Reset
REQ-024 While rst_n=0, asynchronously: pointers=0, count_out=0, out_valid=0, drop_out=0, and in_ready=1 on exit from reset.
REQ-025 Entry storage SHALL not require reset; sum_out, carry_out, op_out and flags_out SHALL read 0 after reset.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk.

Configuration
REQ-027 Macro ADDSUB_RESULT_FLAGS_EN: when defined, the flags storage and logic SHALL be compiled in per REQ-022.
REQ-028 When ADDSUB_RESULT_FLAGS_EN is undefined, the flags storage SHALL be omitted and flags_out SHALL be tied to 3'b000; all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset, then push sum=4'h5, carry=0, op=0 -> next cycle out_valid=1, sum_out=5, flags=000, count=1.
REQ-030 Push 4 entries (1,2,3,4) with out_ready=0 -> in_ready=0, count=4; a fifth push sets drop_out=1; drain returns 1,2,3,4 in order.
REQ-031 At count=2, push and pop in the same cycle repeatedly for 6 cycles -> count stays 2, outputs in FIFO order, pointers wrap correctly.
REQ-032 Push op=1, sum=0, carry=0 -> flags=101 with FLAGS_EN defined, 000 without.
REQ-033 Assert rst_n=0 mid-cycle with count=3 -> count=0 and out_valid=0 immediately, without waiting for a clk edge.
REQ-034 Drop event with clr_in=1 in the same cycle -> drop_out=1; clr_in alone on the next cycle -> drop_out=0.
